// File: rtl/coin_acceptor.sv
// Coin acceptor: measures sensor pulse width, classifies Rs.5 / Rs.10 coins, buffers them in a FIFO.
// Optional 2-flop input synchroniser enabled by defining COIN_SYNC_EN.
module coin_acceptor #(
  parameter int MIN5  = 4,
  parameter int MAX5  = 7,
  parameter int MIN10 = 10,
  parameter int MAX10 = 15,
  parameter int GAP   = 3,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_pulse,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [1:0] coin_code,
  output logic       reject,
  output logic       busy
);
  // Handshake: a head coin transfers on any cycle where coin_valid and coin_ready are both high;
  // coin_valid never depends on coin_ready, and coin_code is stable while coin_valid waits.
  localparam int WW = $clog2(MAX10 + 2);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [WW-1:0] MIN5_W   = WW'(MIN5);
  localparam logic [WW-1:0] MAX5_W   = WW'(MAX5);
  localparam logic [WW-1:0] MIN10_W  = WW'(MIN10);
  localparam logic [WW-1:0] MAX10_W  = WW'(MAX10);
  localparam logic [WW-1:0] SAT_W    = WW'(MAX10 + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, MEASURE, CLASSIFY, STUCK, LOCKOUT} state_t;

  state_t          state, state_n;
  logic [WW-1:0]   wcnt, wcnt_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic            s, s_prev;
  logic            stuck_first, stuck_n;
  logic            cls_push, cls_bad;
  logic [1:0]      cls_code;
  logic            push, pop, full;

  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

`ifdef COIN_SYNC_EN
  logic sync1, sync2;
  // Both flops reset high so a line already high at reset never looks like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= coin_pulse;
      sync2 <= sync1;
    end
  end
  assign s = sync2;
`else
  assign s = coin_pulse;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      gcnt        <= '0;
      s_prev      <= 1'b1;
      stuck_first <= 1'b0;
    end else begin
      state       <= state_n;
      wcnt        <= wcnt_n;
      gcnt        <= gcnt_n;
      s_prev      <= s;
      stuck_first <= stuck_n;
    end
  end

  always_comb begin
    state_n  = state;
    wcnt_n   = wcnt;
    gcnt_n   = gcnt;
    stuck_n  = 1'b0;
    cls_push = 1'b0;
    cls_bad  = 1'b0;
    cls_code = 2'b00;
    case (state)
      IDLE: begin
        if (s && !s_prev) begin
          state_n = MEASURE;
          wcnt_n  = WW'(1);
        end
      end
      MEASURE: begin
        if (!s) begin
          state_n = CLASSIFY;
        end else if (wcnt >= MAX10_W) begin
          state_n = STUCK;
          wcnt_n  = SAT_W;
          stuck_n = 1'b1;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      CLASSIFY: begin
        if (wcnt >= MIN5_W && wcnt <= MAX5_W) begin
          cls_push = 1'b1;
          cls_code = 2'b01;
        end else if (wcnt >= MIN10_W && wcnt <= MAX10_W) begin
          cls_push = 1'b1;
          cls_code = 2'b10;
        end else begin
          cls_bad = 1'b1;
        end
        state_n = LOCKOUT;
        gcnt_n  = '0;
      end
      STUCK: begin
        if (!s) begin
          state_n = LOCKOUT;
          gcnt_n  = '0;
        end
      end
      LOCKOUT: begin
        if (gcnt == GAP_LAST) state_n = IDLE;
        else                  gcnt_n  = gcnt + GW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // A full FIFO still accepts a coin when the head leaves in the same cycle.
  assign full   = (count == DEPTH_W);
  assign pop    = coin_valid && coin_ready;
  assign push   = cls_push && (!full || pop);
  assign reject = cls_bad || (state == STUCK && stuck_first) || (cls_push && full && !pop);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cls_code;
  end

  assign coin_valid = (count != '0);
  assign coin_code  = coin_valid ? mem[rd_ptr] : 2'b00;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with default parameters: classification, stuck coin,
// FIFO overflow, full-FIFO push/pop and reset behaviour.
module tb_coin_acceptor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_pulse = 1'b0;
  logic       coin_ready = 1'b0;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       reject;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int rej_cnt = 0;
  int rej_base;

  coin_acceptor dut (
    .clk        (clk),
    .rst        (rst),
    .coin_pulse (coin_pulse),
    .coin_ready (coin_ready),
    .coin_valid (coin_valid),
    .coin_code  (coin_code),
    .reject     (reject),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reject === 1'b1) rej_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int width);
    coin_pulse = 1'b1;
    repeat (width) tick();
    coin_pulse = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    check("rst_valid", 8'(coin_valid), 8'd0);
    check("rst_code", 8'(coin_code), 8'd0);
    check("rst_reject", 8'(reject), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Rs.5 coin, width 5, consumer ready
    coin_ready = 1'b1;
    rej_base = rej_cnt;
    pulse(5);
    tick();
    check("r5_cls_valid", 8'(coin_valid), 8'd0);
    check("r5_cls_busy", 8'(busy), 8'd1);
    tick();
    check("r5_valid", 8'(coin_valid), 8'd1);
    check("r5_code", 8'(coin_code), 8'h01);
    tick();
    check("r5_popped", 8'(coin_valid), 8'd0);
    check("r5_code_zero", 8'(coin_code), 8'h00);
    tick();
    check("r5_lock_busy", 8'(busy), 8'd1);
    tick();
    check("r5_idle_busy", 8'(busy), 8'd0);
    check("r5_no_reject", 8'(rej_cnt - rej_base), 8'd0);

    // Rs.10 coin, width 12
    pulse(12);
    tick();
    check("r10_cls_reject", 8'(reject), 8'd0);
    tick();
    check("r10_valid", 8'(coin_valid), 8'd1);
    check("r10_code", 8'(coin_code), 8'h02);
    repeat (4) tick();

    // Width 8: between bands
    rej_base = rej_cnt;
    pulse(8);
    tick();
    check("w8_reject", 8'(reject), 8'd1);
    tick();
    check("w8_no_push", 8'(coin_valid), 8'd0);
    repeat (4) tick();
    check("w8_one_reject", 8'(rej_cnt - rej_base), 8'd1);

    // Width 2: too short
    rej_base = rej_cnt;
    pulse(2);
    tick();
    check("w2_reject", 8'(reject), 8'd1);
    tick();
    check("w2_no_push", 8'(coin_valid), 8'd0);
    repeat (4) tick();
    check("w2_one_reject", 8'(rej_cnt - rej_base), 8'd1);

    // Stuck coin: high for 40 cycles
    rej_base = rej_cnt;
    coin_pulse = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 15) check("stuck_k15", 8'(reject), 8'd0);
      if (k == 16) check("stuck_k16", 8'(reject), 8'd1);
      if (k == 17) check("stuck_k17", 8'(reject), 8'd0);
      if (k == 40) check("stuck_busy_high", 8'(busy), 8'd1);
    end
    coin_pulse = 1'b0;
    repeat (3) tick();
    check("stuck_lock_busy", 8'(busy), 8'd1);
    tick();
    check("stuck_idle_busy", 8'(busy), 8'd0);
    check("stuck_one_reject", 8'(rej_cnt - rej_base), 8'd1);
    check("stuck_no_push", 8'(coin_valid), 8'd0);

    // FIFO overflow: five Rs.5 coins with consumer stalled
    coin_ready = 1'b0;
    rej_base = rej_cnt;
    for (int i = 0; i < 4; i++) begin
      pulse(5);
      repeat (6) tick();
    end
    check("ovf_four_no_reject", 8'(rej_cnt - rej_base), 8'd0);
    check("ovf_valid", 8'(coin_valid), 8'd1);
    pulse(5);
    tick();
    check("ovf_fifth_reject", 8'(reject), 8'd1);
    repeat (6) tick();
    check("ovf_one_reject", 8'(rej_cnt - rej_base), 8'd1);
    coin_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_valid", 8'(coin_valid), 8'd1);
      check("ovf_drain_code", 8'(coin_code), 8'h01);
      tick();
    end
    check("ovf_empty_valid", 8'(coin_valid), 8'd0);
    check("ovf_empty_code", 8'(coin_code), 8'h00);

    // Full FIFO, Rs.10 push coinciding with a pop
    coin_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse(5);
      repeat (6) tick();
    end
    rej_base = rej_cnt;
    pulse(12);
    tick();
    coin_ready = 1'b1;
    #1;
    check("pp_no_reject", 8'(reject), 8'd0);
    tick();
    coin_ready = 1'b0;
    repeat (5) tick();
    check("pp_reject_count", 8'(rej_cnt - rej_base), 8'd0);
    coin_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("pp_drain5", 8'(coin_code), 8'h01);
      tick();
    end
    check("pp_drain10_valid", 8'(coin_valid), 8'd1);
    check("pp_drain10", 8'(coin_code), 8'h02);
    tick();
    check("pp_empty", 8'(coin_valid), 8'd0);

    // Reset mid-measurement with a buffered coin
    coin_ready = 1'b0;
    pulse(5);
    repeat (6) tick();
    check("rm_buffered", 8'(coin_valid), 8'd1);
    rej_base = rej_cnt;
    coin_pulse = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rm_valid", 8'(coin_valid), 8'd0);
    check("rm_code", 8'(coin_code), 8'h00);
    check("rm_busy", 8'(busy), 8'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("rm_high_release_busy", 8'(busy), 8'd0);
    check("rm_no_reject", 8'(rej_cnt - rej_base), 8'd0);
    coin_pulse = 1'b0;
    repeat (2) tick();
    pulse(5);
    repeat (2) tick();
    check("rm_after_valid", 8'(coin_valid), 8'd1);
    check("rm_after_code", 8'(coin_code), 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
